id_pipe_stage: RTL and testbench
================================

// Module: id_pipe_stage
// PURPOSE
//  Parametrised, pipelined instruction-decode stage: 2-read/1-write register file,
//  explicit write-back port, WB->ID bypass, load-use interlock, immediate extension.
//  Sits between the IF and EX pipeline registers.
//  Results are registered with one cycle of latency behind a valid/ready handshake.
// PARAMETERS
//  DATA_W      32        datapath / register width
//  RADDR_W     5         register address width; NREGS = 2**RADDR_W
//  REG_INIT    32'd2048  reset value of registers 1..NREGS-1 (register 0 is hardwired to 0)
//  LINK_REG    NREGS-1   destination register index for JAL
// PORTS
//  CLK        in   1        clock
//  RST        in   1        synchronous, active-high reset
//  in_valid   in   1        Ins is valid
//  in_ready   out  1        stage accepts Ins this cycle
//  Ins        in   32       instruction word
//  wb_en      in   1        write-back enable
//  wb_addr    in   RADDR_W  write-back register
//  wb_data    in   DATA_W   write-back data
//  ex_load    in   1        instruction currently in EX is LW
//  ex_rt      in   RADDR_W  destination register of that LW
//  out_valid  out  1        decoded bundle is valid
//  out_ready  in   1        EX accepts the bundle
//  Rdata1     out  DATA_W   rs operand
//  Rdata2     out  DATA_W   rt operand
//  Ed32       out  DATA_W   extended immediate
//  Wreg       out  RADDR_W  destination register
//  Opcode     out  6        Ins[31:26], passed through
// BEHAVIOUR
//  Reset (synchronous RST=1):
//   - out_valid=0; Rdata1/Rdata2/Ed32/Wreg/Opcode=0.
//   - Reg[0]=0; Reg[1..NREGS-1]=REG_INIT.
//   - RST has priority over a write-back in the same cycle. An instruction in flight is dropped.
//  Register file:
//   - Write on posedge when wb_en && wb_addr!=0. Writes to register 0 are ignored.
//   - Reads are combinational on rs=Ins[25:21], rt=Ins[20:16].
//  Bypass:
//   - If wb_en && wb_addr!=0 && wb_addr==rs, the rs operand is wb_data; likewise for rt.
//   - Register 0 always reads as 0.
//  Hazard:
//   - Condition: in_valid && ex_load && ex_rt!=0 && (ex_rt==rs || (ex_rt==rt && uses_rt)).
//   - uses_rt is true for R_FORM, SW, BEQ and BNE.
//   - While the hazard holds: in_ready=0, and a bubble (out_valid=0) is loaded whenever the
//     output register is free.
//  Handshake:
//   - advance = !out_valid || out_ready.
//   - in_ready = advance && !hazard.
//   - Input accepted: out_valid<=1 and the bundle is registered.
//   - advance && !accepted: out_valid<=0.
//   - !advance: all outputs hold unchanged (stall).
//  Destination:
//   - R_FORM -> Ins[15:11]; JAL -> LINK_REG; all other opcodes -> Ins[20:16].
//  Immediate:
//   - R_FORM -> 0.
//   - ANDI, ORI, XORI, LW, SW -> zero-extend Ins[15:0].
//   - All other opcodes -> sign-extend Ins[15:0] to DATA_W.
//  Simultaneous events:
//   - A write-back and a read of the same register in one cycle: the new data is forwarded.
//   - Hazard and a downstream stall together: outputs hold.
// STRUCTURE
//  - Opcode constants (R_FORM, JAL, ANDI, ORI, XORI, LW, SW, BEQ, BNE) live in the shared
//    common_param.vh; add the functions uses_rt and zero_ext_op there.
//  - One sub-module, regfile_2r1w (DATA_W, RADDR_W, REG_INIT): storage, reset, register-0
//    rule, bypass.
//  - Decode, hazard logic and the pipeline register stay in id_pipe_stage.
// TESTING
//  - Reset:
//    - RST for 1 cycle, then Ins=ADDI r1,r2,#1 -> out_valid=1 next cycle.
//    - Rdata1=2048, Ed32=1, Wreg=2.
//  - Bypass:
//    - wb_en=1, wb_addr=3, wb_data=0xDEADBEEF in the same cycle as R-form rs=3.
//    - -> Rdata1=0xDEADBEEF.
//  - Extension:
//    - ORI imm=0x8000 -> Ed32=0x00008000.
//    - ADDI imm=0x8000 -> Ed32=0xFFFF8000.
//    - R_FORM -> Ed32=0.
//  - Load-use:
//    - ex_load=1, ex_rt=5, Ins rs=5 -> in_ready=0 and a bubble out.
//    - Drop ex_load -> accepted the next cycle.
//    - ex_rt=0 -> no stall.
//  - Backpressure:
//    - out_ready=0 for 3 cycles -> outputs stable, in_ready=0.
//    - Release -> exactly one transfer per cycle.
//  - Misc:
//    - JAL -> Wreg=31.
//    - Write to r0 -> a subsequent read of r0 returns 0.
//    - RST mid-stall -> out_valid=0.

Source files
------------

// File: rtl/id_pipe_stage_pkg.sv
// Shared opcode constants, instruction field layout and decode helpers
// for the instruction-decode pipeline stage.
package id_pipe_stage_pkg;

  typedef enum logic [5:0] {
    R_FORM = 6'h00,
    JAL    = 6'h03,
    BEQ    = 6'h04,
    BNE    = 6'h05,
    ADDI   = 6'h08,
    ANDI   = 6'h0C,
    ORI    = 6'h0D,
    XORI   = 6'h0E,
    LW     = 6'h23,
    SW     = 6'h2B
  } opcode_e;

  // R-form rd lives in imm[15:11]
  typedef struct packed {
    logic [5:0]  op;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [15:0] imm;
  } ins_fields_t;

  function automatic logic uses_rt(input logic [5:0] op);
    case (op)
      R_FORM, SW, BEQ, BNE: return 1'b1;
      default:              return 1'b0;
    endcase
  endfunction

  function automatic logic zero_ext_op(input logic [5:0] op);
    case (op)
      ANDI, ORI, XORI, LW, SW: return 1'b1;
      default:                 return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/id_pipe_stage_if.sv
// Pipeline bus of the decode stage: IF-side handshake, write-back port,
// EX load information and the registered decoded bundle towards EX.
interface id_pipe_stage_if #(
  parameter int DATA_W  = 32,
  parameter int RADDR_W = 5
);
  logic               in_valid;
  logic               in_ready;
  logic [31:0]        Ins;
  logic               wb_en;
  logic [RADDR_W-1:0] wb_addr;
  logic [DATA_W-1:0]  wb_data;
  logic               ex_load;
  logic [RADDR_W-1:0] ex_rt;
  logic               out_valid;
  logic               out_ready;
  logic [DATA_W-1:0]  Rdata1;
  logic [DATA_W-1:0]  Rdata2;
  logic [DATA_W-1:0]  Ed32;
  logic [RADDR_W-1:0] Wreg;
  logic [5:0]         Opcode;

  modport master (
    output in_valid, Ins, wb_en, wb_addr, wb_data, ex_load, ex_rt, out_ready,
    input  in_ready, out_valid, Rdata1, Rdata2, Ed32, Wreg, Opcode
  );

  modport slave (
    input  in_valid, Ins, wb_en, wb_addr, wb_data, ex_load, ex_rt, out_ready,
    output in_ready, out_valid, Rdata1, Rdata2, Ed32, Wreg, Opcode
  );
endinterface

// File: rtl/id_pipe_stage_regfile.sv
// Two-read/one-write register file with register 0 tied to zero and
// same-cycle write-back forwarding onto both read ports.
module regfile_2r1w #(
  parameter int                DATA_W   = 32,
  parameter int                RADDR_W  = 5,
  parameter logic [DATA_W-1:0] REG_INIT = 32'd2048
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic [RADDR_W-1:0] raddr1,
  input  logic [RADDR_W-1:0] raddr2,
  input  logic               wen,
  input  logic [RADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0]  wdata,
  output logic [DATA_W-1:0]  rdata1,
  output logic [DATA_W-1:0]  rdata2
);

  localparam int NREGS = 2 ** RADDR_W;

  logic [DATA_W-1:0] mem [NREGS];
  logic              bypass1;
  logic              bypass2;

  // Reset wins over a coincident write-back
  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int i = 0; i < NREGS; i++) begin
        mem[i] <= (i == 0) ? '0 : REG_INIT;
      end
    end else if (wen && (waddr != '0)) begin
      mem[waddr] <= wdata;
    end
  end

  assign bypass1 = wen && (waddr == raddr1);
  assign bypass2 = wen && (waddr == raddr2);

  assign rdata1 = (raddr1 == '0) ? '0 : (bypass1 ? wdata : mem[raddr1]);
  assign rdata2 = (raddr2 == '0) ? '0 : (bypass2 ? wdata : mem[raddr2]);

endmodule

// File: rtl/id_pipe_stage.sv
// Instruction-decode stage: operand read with WB bypass, load-use interlock,
// immediate extension and a one-deep valid/ready output register towards EX.
module id_pipe_stage #(
  parameter int                DATA_W   = 32,
  parameter int                RADDR_W  = 5,
  parameter logic [DATA_W-1:0] REG_INIT = 32'd2048,
  parameter int                LINK_REG = (2 ** RADDR_W) - 1
) (
  input logic              CLK,
  input logic              RST,
  id_pipe_stage_if.slave   bus
);

  import id_pipe_stage_pkg::*;

  localparam logic [RADDR_W-1:0] LINK_IDX = RADDR_W'(LINK_REG);

  ins_fields_t        f;
  logic [RADDR_W-1:0] rs;
  logic [RADDR_W-1:0] rt;
  logic [RADDR_W-1:0] rd;
  logic [DATA_W-1:0]  rdata1;
  logic [DATA_W-1:0]  rdata2;
  logic [DATA_W-1:0]  ed_d;
  logic [RADDR_W-1:0] wreg_d;
  logic               hazard;
  logic               advance;
  logic               in_ready;
  logic               accept;

  logic               out_valid_q;
  logic [DATA_W-1:0]  rdata1_q;
  logic [DATA_W-1:0]  rdata2_q;
  logic [DATA_W-1:0]  ed_q;
  logic [RADDR_W-1:0] wreg_q;
  logic [5:0]         opcode_q;

  assign f  = bus.Ins;
  assign rs = RADDR_W'(f.rs);
  assign rt = RADDR_W'(f.rt);
  assign rd = RADDR_W'(f.imm[15:11]);

  regfile_2r1w #(
    .DATA_W  (DATA_W),
    .RADDR_W (RADDR_W),
    .REG_INIT(REG_INIT)
  ) u_regfile (
    .CLK   (CLK),
    .RST   (RST),
    .raddr1(rs),
    .raddr2(rt),
    .wen   (bus.wb_en),
    .waddr (bus.wb_addr),
    .wdata (bus.wb_data),
    .rdata1(rdata1),
    .rdata2(rdata2)
  );

  // rt only matters for the interlock when the instruction actually reads it
  assign hazard = bus.in_valid && bus.ex_load && (bus.ex_rt != '0) &&
                  ((bus.ex_rt == rs) || ((bus.ex_rt == rt) && uses_rt(f.op)));

  assign advance  = !out_valid_q || bus.out_ready;
  assign in_ready = advance && !hazard;
  assign accept   = bus.in_valid && in_ready;

  always_comb begin
    wreg_d = rt;
    ed_d   = DATA_W'($signed(f.imm));
    if (f.op == R_FORM) begin
      wreg_d = rd;
      ed_d   = '0;
    end else if (f.op == JAL) begin
      wreg_d = LINK_IDX;
    end else if (zero_ext_op(f.op)) begin
      ed_d   = DATA_W'(f.imm);
    end
  end

  // Output register: load on accept, drain to a bubble when free, hold on stall
  always_ff @(posedge CLK) begin
    if (RST) begin
      out_valid_q <= 1'b0;
      rdata1_q    <= '0;
      rdata2_q    <= '0;
      ed_q        <= '0;
      wreg_q      <= '0;
      opcode_q    <= '0;
    end else if (accept) begin
      out_valid_q <= 1'b1;
      rdata1_q    <= rdata1;
      rdata2_q    <= rdata2;
      ed_q        <= ed_d;
      wreg_q      <= wreg_d;
      opcode_q    <= f.op;
    end else if (advance) begin
      out_valid_q <= 1'b0;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid_q;
  assign bus.Rdata1    = rdata1_q;
  assign bus.Rdata2    = rdata2_q;
  assign bus.Ed32      = ed_q;
  assign bus.Wreg      = wreg_q;
  assign bus.Opcode    = opcode_q;

endmodule

// File: tb/tb_id_pipe_stage.sv
// Scoreboard bench for id_pipe_stage: directed corner cases followed by
// random traffic, all compared against a behavioural decode model.
module tb_id_pipe_stage;

  localparam logic [5:0] OP_R    = 6'h00;
  localparam logic [5:0] OP_JAL  = 6'h03;
  localparam logic [5:0] OP_BEQ  = 6'h04;
  localparam logic [5:0] OP_BNE  = 6'h05;
  localparam logic [5:0] OP_ADDI = 6'h08;
  localparam logic [5:0] OP_ANDI = 6'h0C;
  localparam logic [5:0] OP_ORI  = 6'h0D;
  localparam logic [5:0] OP_XORI = 6'h0E;
  localparam logic [5:0] OP_LW   = 6'h23;
  localparam logic [5:0] OP_SW   = 6'h2B;

  typedef struct {
    logic [31:0] r1;
    logic [31:0] r2;
    logic [31:0] ed;
    logic [4:0]  wreg;
    logic [5:0]  op;
  } exp_t;

  logic        CLK;
  logic        RST;
  int          vectors = 0;
  int          miscompares = 0;
  exp_t        sb[$];
  logic [31:0] refRegs [32];
  logic [5:0]  opList [11];

  id_pipe_stage_if #(.DATA_W(32), .RADDR_W(5)) bus ();

  id_pipe_stage #(
    .DATA_W  (32),
    .RADDR_W (5),
    .REG_INIT(32'd2048),
    .LINK_REG(31)
  ) dut (
    .CLK(CLK),
    .RST(RST),
    .bus(bus)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  function automatic logic [31:0] mkI(input logic [5:0] op, input int rs, input int rt,
                                      input logic [15:0] imm);
    return {op, 5'(rs), 5'(rt), imm};
  endfunction

  function automatic logic [31:0] mkR(input int rs, input int rt, input int rd);
    return {OP_R, 5'(rs), 5'(rt), 5'(rd), 11'h000};
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference rules, stated directly on the instruction fields
  function automatic logic refHazard();
    logic [5:0] op;
    op = bus.Ins[31:26];
    return bus.in_valid && bus.ex_load && (bus.ex_rt != 5'd0) &&
           ((bus.ex_rt == bus.Ins[25:21]) ||
            ((bus.ex_rt == bus.Ins[20:16]) && (op inside {OP_R, OP_SW, OP_BEQ, OP_BNE})));
  endfunction

  function automatic logic [31:0] refRead(input logic [4:0] a);
    if (a == 5'd0) return 32'd0;
    if (bus.wb_en && (bus.wb_addr == a)) return bus.wb_data;
    return refRegs[a];
  endfunction

  function automatic exp_t refPredict();
    exp_t        e;
    logic [5:0]  op;
    logic [15:0] imm;
    op   = bus.Ins[31:26];
    imm  = bus.Ins[15:0];
    e.r1 = refRead(bus.Ins[25:21]);
    e.r2 = refRead(bus.Ins[20:16]);
    e.op = op;
    if (op == OP_R)        e.wreg = bus.Ins[15:11];
    else if (op == OP_JAL) e.wreg = 5'd31;
    else                   e.wreg = bus.Ins[20:16];
    if (op == OP_R)                                         e.ed = 32'd0;
    else if (op inside {OP_ANDI, OP_ORI, OP_XORI, OP_LW, OP_SW}) e.ed = {16'h0000, imm};
    else                                                    e.ed = {{16{imm[15]}}, imm};
    return e;
  endfunction

  // Predictor: decides acceptance at each edge and queues the expected bundle
  always @(posedge CLK) begin
    if (RST) begin
      sb.delete();
      for (int i = 0; i < 32; i++) refRegs[i] = (i == 0) ? 32'd0 : 32'd2048;
    end else begin
      if (bus.in_valid && ((sb.size() == 0) || bus.out_ready) && !refHazard())
        sb.push_back(refPredict());
      if (bus.wb_en && (bus.wb_addr != 5'd0)) refRegs[bus.wb_addr] = bus.wb_data;
    end
  end

  // Monitor: compares whatever the DUT presents against the queue head
  always @(negedge CLK) begin : monitor
    logic expReady;
    expReady = ((sb.size() == 0) || bus.out_ready) && !refHazard();
    checkOutput("in_ready", 32'(bus.in_ready), 32'(expReady));
    checkOutput("out_valid", 32'(bus.out_valid), 32'(sb.size() != 0));
    if (sb.size() != 0) begin
      checkOutput("sb_Rdata1", bus.Rdata1, sb[0].r1);
      checkOutput("sb_Rdata2", bus.Rdata2, sb[0].r2);
      checkOutput("sb_Ed32",   bus.Ed32,   sb[0].ed);
      checkOutput("sb_Wreg",   32'(bus.Wreg),   32'(sb[0].wreg));
      checkOutput("sb_Opcode", 32'(bus.Opcode), 32'(sb[0].op));
      if (bus.out_ready) void'(sb.pop_front());
    end
  end

  task automatic applyStimulus(input logic v, input logic [31:0] ins,
                               input logic wbe = 1'b0, input logic [4:0] wba = 5'd0,
                               input logic [31:0] wbd = 32'd0, input logic exl = 1'b0,
                               input logic [4:0] exr = 5'd0, input logic ordy = 1'b1);
    bus.in_valid  = v;
    bus.Ins       = ins;
    bus.wb_en     = wbe;
    bus.wb_addr   = wba;
    bus.wb_data   = wbd;
    bus.ex_load   = exl;
    bus.ex_rt     = exr;
    bus.out_ready = ordy;
    #1;
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  initial begin
    opList = '{OP_R, OP_JAL, OP_BEQ, OP_BNE, OP_ADDI, OP_ANDI, OP_ORI, OP_XORI, OP_LW, OP_SW, 6'h3F};
    RST = 1'b1;
    applyStimulus(1'b0, 32'd0);
    tick();
    RST = 1'b0;
    checkOutput("reset_out_valid", 32'(bus.out_valid), 32'd0);
    checkOutput("reset_Rdata1", bus.Rdata1, 32'd0);
    checkOutput("reset_Wreg", 32'(bus.Wreg), 32'd0);

    applyStimulus(1'b1, mkI(OP_ADDI, 1, 2, 16'd1));
    tick();
    checkOutput("addi_valid", 32'(bus.out_valid), 32'd1);
    checkOutput("addi_Rdata1", bus.Rdata1, 32'd2048);
    checkOutput("addi_Ed32", bus.Ed32, 32'd1);
    checkOutput("addi_Wreg", 32'(bus.Wreg), 32'd2);

    applyStimulus(1'b1, mkR(3, 4, 7), 1'b1, 5'd3, 32'hDEADBEEF);
    tick();
    checkOutput("bypass_Rdata1", bus.Rdata1, 32'hDEADBEEF);
    checkOutput("rform_Ed32", bus.Ed32, 32'd0);
    checkOutput("rform_Wreg", 32'(bus.Wreg), 32'd7);

    applyStimulus(1'b1, mkI(OP_ORI, 3, 6, 16'h8000));
    tick();
    checkOutput("ori_Ed32", bus.Ed32, 32'h00008000);
    checkOutput("written_Rdata1", bus.Rdata1, 32'hDEADBEEF);
    applyStimulus(1'b1, mkI(OP_ADDI, 0, 6, 16'h8000));
    tick();
    checkOutput("addi_sext_Ed32", bus.Ed32, 32'hFFFF8000);

    // Load-use on rs
    applyStimulus(1'b1, mkI(OP_ADDI, 5, 6, 16'd4), 1'b0, 5'd0, 32'd0, 1'b1, 5'd5);
    checkOutput("loaduse_in_ready", 32'(bus.in_ready), 32'd0);
    tick();
    checkOutput("loaduse_bubble", 32'(bus.out_valid), 32'd0);
    applyStimulus(1'b1, mkI(OP_ADDI, 5, 6, 16'd4));
    checkOutput("loaduse_release_ready", 32'(bus.in_ready), 32'd1);
    tick();
    checkOutput("loaduse_release_valid", 32'(bus.out_valid), 32'd1);
    applyStimulus(1'b1, mkI(OP_ADDI, 1, 5, 16'd0), 1'b0, 5'd0, 32'd0, 1'b1, 5'd5);
    checkOutput("addi_rt_no_stall", 32'(bus.in_ready), 32'd1);
    tick();
    applyStimulus(1'b1, mkI(OP_SW, 1, 5, 16'd0), 1'b0, 5'd0, 32'd0, 1'b1, 5'd5);
    checkOutput("sw_rt_stall", 32'(bus.in_ready), 32'd0);
    tick();
    applyStimulus(1'b1, mkI(OP_ADDI, 0, 0, 16'd0), 1'b0, 5'd0, 32'd0, 1'b1, 5'd0);
    checkOutput("ex_rt0_no_stall", 32'(bus.in_ready), 32'd1);
    tick();

    // Backpressure: hold for three cycles, then stream one per cycle
    applyStimulus(1'b1, mkI(OP_ADDI, 2, 9, 16'h0042));
    tick();
    applyStimulus(1'b1, mkI(OP_ORI, 4, 10, 16'h1234), 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      checkOutput("bp_in_ready", 32'(bus.in_ready), 32'd0);
      tick();
      checkOutput("bp_hold_Ed32", bus.Ed32, 32'h00000042);
      checkOutput("bp_hold_valid", 32'(bus.out_valid), 32'd1);
    end
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b1, mkI(OP_ORI, 4, 10, 16'(16'h1234 + i)));
      checkOutput("stream_in_ready", 32'(bus.in_ready), 32'd1);
      tick();
      checkOutput("stream_Ed32", bus.Ed32, 32'(16'h1234 + i));
    end

    applyStimulus(1'b1, mkI(OP_JAL, 0, 0, 16'h0010));
    tick();
    checkOutput("jal_Wreg", 32'(bus.Wreg), 32'd31);

    applyStimulus(1'b1, mkR(0, 0, 1), 1'b1, 5'd0, 32'd123);
    tick();
    checkOutput("r0_bypass_Rdata1", bus.Rdata1, 32'd0);
    applyStimulus(1'b1, mkR(0, 0, 1));
    tick();
    checkOutput("r0_read_Rdata2", bus.Rdata2, 32'd0);

    // Reset while the output is stalled
    applyStimulus(1'b1, mkI(OP_ADDI, 1, 1, 16'd5), 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 1'b0);
    tick();
    RST = 1'b1;
    tick();
    RST = 1'b0;
    checkOutput("rst_stall_valid", 32'(bus.out_valid), 32'd0);
    applyStimulus(1'b1, mkR(3, 0, 2));
    tick();
    checkOutput("rst_reinit_Rdata1", bus.Rdata1, 32'd2048);

    for (int n = 0; n < 400; n++) begin
      logic [5:0] op;
      op = opList[$urandom_range(10, 0)];
      applyStimulus(($urandom_range(3, 0) != 0),
                    mkI(op, $urandom_range(7, 0), $urandom_range(7, 0), 16'($urandom)),
                    ($urandom_range(1, 0) == 1), 5'($urandom_range(7, 0)), $urandom,
                    ($urandom_range(3, 0) == 0), 5'($urandom_range(7, 0)),
                    ($urandom_range(9, 0) < 7));
      tick();
    end

    applyStimulus(1'b0, 32'd0);
    repeat (4) tick();
    checkOutput("drain_empty", 32'(sb.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
